// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I size codes, FSM states, and the illegal-encoding check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsuState_t;

  // Stores have no unsigned variants, so any 1xx code is illegal for them.
  function automatic logic funct3Illegal(input logic [2:0] f3, input logic isStore);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (isStore && f3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus: request/grant for the address phase, rvalid for read data.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store strobes with replicated write data, and load lane select with extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  stFunct3,
  input  logic [1:0]  stOffset,
  input  logic [31:0] stData,
  output logic [3:0]  stStrb,
  output logic [31:0] stWdata,
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldOffset,
  input  logic [31:0] ldRaw,
  output logic [31:0] ldData
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  always_comb begin
    stStrb  = 4'b1111;
    stWdata = stData;
    case (stFunct3[1:0])
      2'b00: begin
        stStrb  = 4'b0001 << stOffset;
        stWdata = {4{stData[7:0]}};
      end
      2'b01: begin
        stStrb  = 4'b0011 << {stOffset[1], 1'b0};
        stWdata = {2{stData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldByte = ldRaw[7:0];
    case (ldOffset)
      2'd1:    ldByte = ldRaw[15:8];
      2'd2:    ldByte = ldRaw[23:16];
      2'd3:    ldByte = ldRaw[31:24];
      default: ldByte = ldRaw[7:0];
    endcase
    ldHalf = ldOffset[1] ? ldRaw[31:16] : ldRaw[15:0];

    ldData = '0;
    case (ldFunct3)
      F3_B:    ldData = {{24{ldByte[7]}}, ldByte};
      F3_BU:   ldData = {24'd0, ldByte};
      F3_H:    ldData = {{16{ldHalf[15]}}, ldHalf};
      F3_HU:   ldData = {16'd0, ldHalf};
      F3_W:    ldData = ldRaw;
      default: ldData = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine with watchdog; LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
// Min latency store 2 / load 3 cycles after accept; StallM holds upstream until the one-cycle DoneM pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     LoadM,
  input  logic                     StoreM,
  input  logic [2:0]               Funct3M,
  input  logic [31:0]              ALU_ResultM,
  input  logic [31:0]              WriteDataM,
  output logic [31:0]              ReadDataM,
  output logic                     DoneM,
  output logic                     StallM,
  output logic                     MisalignM,
  output logic                     TimeoutM,
  load_store_unit_if.master        mem
);

  lsuState_t            state;
  logic [2:0]           funct3Q;
  logic [1:0]           offQ;
  logic                 isLoadQ;
  logic [TIMEOUT_W-1:0] wdogCnt;

  logic        start;
  logic        isLoad;
  logic        illegal;
  logic        misalign;
  logic [31:0] reqAddr;
  logic        timeoutHit;
  logic [3:0]  stStrb;
  logic [31:0] stWdata;
  logic [31:0] ldData;

  assign start   = LoadM | StoreM;
  assign isLoad  = LoadM;
  assign illegal = funct3Illegal(Funct3M, !isLoad);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = !illegal &&
                    (((Funct3M[1:0] == 2'b01) && ALU_ResultM[0]) ||
                     ((Funct3M[1:0] == 2'b10) && (ALU_ResultM[1:0] != 2'b00)));
  assign reqAddr  = ALU_ResultM;
`else
  assign misalign = 1'b0;
  always_comb begin
    case (Funct3M[1:0])
      2'b01:   reqAddr = {ALU_ResultM[31:1], 1'b0};
      2'b10:   reqAddr = {ALU_ResultM[31:2], 2'b00};
      default: reqAddr = ALU_ResultM;
    endcase
  end
`endif

  // Abort on the last allowed REQ/WAIT cycle unless that cycle completes the access.
  assign timeoutHit = (TIMEOUT_CYCLES != 0) &&
                      (wdogCnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  assign StallM = rst && ((state == IDLE && start) || state == REQ || state == WAIT);

  lsu_lane_align u_lane (
    .stFunct3 (Funct3M),
    .stOffset (reqAddr[1:0]),
    .stData   (WriteDataM),
    .stStrb   (stStrb),
    .stWdata  (stWdata),
    .ldFunct3 (funct3Q),
    .ldOffset (offQ),
    .ldRaw    (mem.mem_rdata),
    .ldData   (ldData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      funct3Q       <= '0;
      offQ          <= '0;
      isLoadQ       <= 1'b0;
      wdogCnt       <= '0;
      DoneM         <= 1'b0;
      ReadDataM     <= '0;
      MisalignM     <= 1'b0;
      TimeoutM      <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
    end else begin
      DoneM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            funct3Q <= Funct3M;
            offQ    <= reqAddr[1:0];
            isLoadQ <= isLoad;
            wdogCnt <= '0;
            if (illegal || misalign) begin
              state     <= DONE;
              DoneM     <= 1'b1;
              ReadDataM <= '0;
              MisalignM <= misalign;
              TimeoutM  <= 1'b0;
            end else begin
              state         <= REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= !isLoad;
              mem.mem_addr  <= {reqAddr[31:2], 2'b00};
              mem.mem_wstrb <= isLoad ? 4'b0000 : stStrb;
              mem.mem_wdata <= isLoad ? 32'd0 : stWdata;
            end
          end
        end
        REQ: begin
          if (mem.mem_gnt && !isLoadQ) begin
            state         <= DONE;
            DoneM         <= 1'b1;
            ReadDataM     <= '0;
            MisalignM     <= 1'b0;
            TimeoutM      <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
          end else if (timeoutHit) begin
            state         <= DONE;
            DoneM         <= 1'b1;
            ReadDataM     <= '0;
            MisalignM     <= 1'b0;
            TimeoutM      <= 1'b1;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
          end else begin
            wdogCnt <= wdogCnt + 1'b1;
            if (mem.mem_gnt) begin
              state       <= WAIT;
              mem.mem_req <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            state     <= DONE;
            DoneM     <= 1'b1;
            ReadDataM <= ldData;
            MisalignM <= 1'b0;
            TimeoutM  <= 1'b0;
          end else if (timeoutHit) begin
            state     <= DONE;
            DoneM     <= 1'b1;
            ReadDataM <= '0;
            MisalignM <= 1'b0;
            TimeoutM  <= 1'b1;
          end else begin
            wdogCnt <= wdogCnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a size/offset arithmetic model of RV32I accesses.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        LoadM = 1'b0;
  logic        StoreM = 1'b0;
  logic [2:0]  Funct3M = '0;
  logic [31:0] ALU_ResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        DoneM, StallM, MisalignM, TimeoutM;

  int checks = 0;
  int errors = 0;

  load_store_unit_if memBus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .LoadM       (LoadM),
    .StoreM      (StoreM),
    .Funct3M     (Funct3M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .ReadDataM   (ReadDataM),
    .DoneM       (DoneM),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .TimeoutM    (TimeoutM),
    .mem         (memBus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] loadModel(input logic [2:0] f3, input int off, input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return raw;
      default: return 32'd0;
    endcase
  endfunction

  // Called on a falling edge with the DUT idle; leaves on the falling edge of the following idle cycle.
  task automatic runAccess(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int gntDly, input int rvDly);
    bit isLoad, illegal, mis, skip, to, inReq;
    int size, doneCyc, n;
    logic [31:0] effAddr, expRead, expWd;
    logic [3:0] expStrb;
    isLoad  = ld;
    size    = f3 % 4;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (!isLoad && f3 >= 4);
`ifdef LSU_MISALIGN_TRAP_EN
    mis     = !illegal && ((size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0));
    effAddr = addr;
`else
    mis     = 0;
    effAddr = (size == 1) ? addr - addr % 2 : (size == 2) ? addr - addr % 4 : addr;
`endif
    skip = illegal || mis;
    if (skip) begin
      to = 0; doneCyc = 1;
    end else if (!isLoad) begin
      to = (gntDly + 1) > TO;
      doneCyc = to ? TO + 1 : gntDly + 2;
    end else begin
      n = gntDly + rvDly + 2;
      to = n > TO;
      doneCyc = to ? TO + 1 : n + 1;
    end
    expRead = (skip || to || !isLoad) ? 32'd0 : loadModel(f3, effAddr % 4, rd);
    expStrb = (size == 0) ? 4'(1 << (effAddr % 4)) : (size == 1) ? 4'(3 << (effAddr % 4)) : 4'hF;
    expWd   = (size == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
              (size == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;

    LoadM = ld; StoreM = st; Funct3M = f3; ALU_ResultM = addr; WriteDataM = wd;
    memBus.mem_rdata = rd; memBus.mem_gnt = 1'b0; memBus.mem_rvalid = 1'b0;
    #1;
    chk({tag, " stall@accept"}, StallM, 1);
    for (int c = 1; c <= doneCyc; c++) begin
      @(negedge clk);
      inReq = !skip && (c <= gntDly + 1) && (c <= TO);
      chk({tag, " req"}, memBus.mem_req, inReq);
      chk({tag, " done"}, DoneM, c == doneCyc);
      chk({tag, " stall"}, StallM, c != doneCyc);
      if (c == 1 && inReq) begin
        chk({tag, " addr"}, memBus.mem_addr, effAddr - effAddr % 4);
        chk({tag, " we"}, memBus.mem_we, !isLoad);
        if (!isLoad) begin
          chk({tag, " wstrb"}, memBus.mem_wstrb, expStrb);
          chk({tag, " wdata"}, memBus.mem_wdata, expWd);
        end
      end
      if (c == doneCyc) begin
        chk({tag, " timeout"}, TimeoutM, to);
        chk({tag, " misalign"}, MisalignM, mis);
        if (isLoad || skip) chk({tag, " rdata"}, ReadDataM, expRead);
        LoadM = 0; StoreM = 0; memBus.mem_gnt = 0; memBus.mem_rvalid = 0;
      end else begin
        LoadM = 1'($urandom); StoreM = 1'($urandom);
        Funct3M = 3'($urandom); ALU_ResultM = $urandom; WriteDataM = $urandom;
        memBus.mem_gnt = inReq && (c == gntDly + 1);
        memBus.mem_rvalid = inReq ? 1'($urandom) : (isLoad && c == gntDly + 2 + rvDly);
      end
    end
    @(negedge clk);
    chk({tag, " idle done"}, DoneM, 0);
    chk({tag, " idle stall"}, StallM, 0);
    chk({tag, " idle req"}, memBus.mem_req, 0);
  endtask

  initial begin
    memBus.mem_gnt = 0; memBus.mem_rvalid = 0; memBus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst rdata", ReadDataM, 0);
    chk("rst done", DoneM, 0);
    chk("rst stall", StallM, 0);
    chk("rst misalign", MisalignM, 0);
    chk("rst timeout", TimeoutM, 0);
    chk("rst req", memBus.mem_req, 0);
    chk("rst we", memBus.mem_we, 0);
    chk("rst addr", memBus.mem_addr, 0);
    chk("rst wstrb", memBus.mem_wstrb, 0);
    chk("rst wdata", memBus.mem_wdata, 0);
    rst = 1;
    @(negedge clk);

    runAccess("SB103", 0, 1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
    runAccess("LB102", 1, 0, 3'b000, 32'h102, 32'h0, 32'h0080_FF00, 0, 0);
    runAccess("LHU202", 1, 0, 3'b101, 32'h202, 32'h0, 32'h8001_1234, 0, 0);
    runAccess("LH202", 1, 0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 0, 0);
    runAccess("SH202", 0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 1, 0);
    runAccess("SW", 0, 1, 3'b010, 32'h500, 32'h1234_5678, 32'h0, 0, 0);
    runAccess("LWslow", 1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 10, 2);
    runAccess("SWtimeout", 0, 1, 3'b010, 32'h600, 32'h5555_AAAA, 32'h0, 100, 0);
    runAccess("LWtimeout", 1, 0, 3'b010, 32'h700, 32'h0, 32'h1111_2222, 100, 0);
    memBus.mem_rvalid = 1; memBus.mem_gnt = 1;
    repeat (2) begin
      @(negedge clk);
      chk("late resp done", DoneM, 0);
      chk("late resp req", memBus.mem_req, 0);
      chk("late resp rdata", ReadDataM, 0);
    end
    memBus.mem_rvalid = 0; memBus.mem_gnt = 0;
    runAccess("LW101", 1, 0, 3'b010, 32'h101, 32'h0, 32'h8765_4321, 0, 0);
    runAccess("LH203", 1, 0, 3'b001, 32'h203, 32'h0, 32'h8765_4321, 0, 1);
    runAccess("ILL011", 1, 0, 3'b011, 32'h100, 32'h0, 32'hFFFF_FFFF, 0, 0);
    runAccess("ILLst1xx", 0, 1, 3'b100, 32'h100, 32'hFF, 32'h0, 0, 0);
    runAccess("LDST_BOTH", 1, 1, 3'b100, 32'h101, 32'hFF, 32'h0000_9A00, 0, 0);

    // Reset while requesting drops mem_req and StallM at once.
    LoadM = 1; Funct3M = 3'b010; ALU_ResultM = 32'h300;
    @(negedge clk);
    chk("pre-rst req", memBus.mem_req, 1);
    rst = 0; #1;
    chk("rst-in-REQ req", memBus.mem_req, 0);
    chk("rst-in-REQ stall", StallM, 0);
    LoadM = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("post-rst stall", StallM, 0);
    LoadM = 1; memBus.mem_gnt = 1;
    @(negedge clk);
    LoadM = 0;
    @(negedge clk);
    memBus.mem_gnt = 0;
    chk("in WAIT stall", StallM, 1);
    rst = 0; #1;
    chk("rst-in-WAIT stall", StallM, 0);
    chk("rst-in-WAIT req", memBus.mem_req, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("post-rst2 done", DoneM, 0);

    for (int i = 0; i < 60; i++) begin
      logic ld, st;
      int gd;
      ld = 1'($urandom);
      st = !ld || 1'($urandom);
      gd = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 5));
      runAccess($sformatf("rnd%0d", i), ld, st, 3'($urandom), $urandom, $urandom, $urandom,
                gd, int'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
